// File: rtl/xor_crc.sv
`default_nettype none
// ============================================================================
// Module   : xor_crc
// Brief    : Bit-serial XOR/CRC accumulator. It folds DATA_W-bit words into a
//            WIDTH-bit LFSR, MSB first, and pulses out_valid after each word.
// Revision : 1.0 - initial release
// ============================================================================
module xor_crc #(
    parameter int              WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'h1021,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}},
    parameter int              DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              busy,
    output logic [WIDTH-1:0]  crc
);

    localparam int c_cnt_w = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_crc;
    logic [DATA_W-1:0]  r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rdy_en;

    logic               w_fb;
    logic [WIDTH-1:0]   w_crc_next;

    // A whole-vector shift yields zero for WIDTH=1, so no sub-range of r_crc is needed.
    assign w_fb       = r_crc[WIDTH-1] ^ r_shreg[DATA_W-1];
    assign w_crc_next = (r_crc << 1) ^ (w_fb ? POLY : {WIDTH{1'b0}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_crc    <= INIT;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (clear) begin
                r_state <= S_IDLE;
                r_crc   <= INIT;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (in_valid && in_ready) begin
                            r_shreg <= in_data;
                            r_cnt   <= '0;
                            r_state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        r_crc   <= w_crc_next;
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // rst_n gates in_ready directly so it drops as soon as reset is asserted.
    assign in_ready  = (r_state == S_IDLE) && r_rdy_en && rst_n;
    assign busy      = (r_state == S_SHIFT);
    assign out_valid = (r_state == S_DONE);
    assign crc       = r_crc;

endmodule
`default_nettype wire
